priority_resolver: RTL

PRIORITY_RESOLVER -- requirements
Module: priority_resolver

---
 rtl/priority_resolver.sv | 90 +++++++++
 1 files changed

// File: rtl/priority_resolver.sv
// priority_resolver: 13-engine confirm-result resolver, highest priority wins, lower engine breaks ties
// Ports: clk, rst (sync, active-high), i_Valid + i_Confirm_Result1..13 in;
//   o_Valid, o_Match, o_Rule_ID, o_Rule_Prior, o_Engine_Idx out, 4 cycles later.
// Optional statistics (i_Stats_Clear, o_Hit_Count, o_Miss_Count) with PRIORITY_RESOLVER_STATS_EN.
module priority_resolver #(
  parameter int CFWID = 17,
  parameter int IDWID = 8,
  parameter int PRIOR = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_Valid,
  input  logic [CFWID-1:0] i_Confirm_Result1,
  input  logic [CFWID-1:0] i_Confirm_Result2,
  input  logic [CFWID-1:0] i_Confirm_Result3,
  input  logic [CFWID-1:0] i_Confirm_Result4,
  input  logic [CFWID-1:0] i_Confirm_Result5,
  input  logic [CFWID-1:0] i_Confirm_Result6,
  input  logic [CFWID-1:0] i_Confirm_Result7,
  input  logic [CFWID-1:0] i_Confirm_Result8,
  input  logic [CFWID-1:0] i_Confirm_Result9,
  input  logic [CFWID-1:0] i_Confirm_Result10,
  input  logic [CFWID-1:0] i_Confirm_Result11,
  input  logic [CFWID-1:0] i_Confirm_Result12,
  input  logic [CFWID-1:0] i_Confirm_Result13,
`ifdef PRIORITY_RESOLVER_STATS_EN
  input  logic             i_Stats_Clear,
  output logic [31:0]      o_Hit_Count,
  output logic [31:0]      o_Miss_Count,
`endif
  output logic             o_Valid,
  output logic             o_Match,
  output logic [IDWID-1:0] o_Rule_ID,
  output logic [PRIOR-1:0] o_Rule_Prior,
  output logic [3:0]       o_Engine_Idx
);
  localparam int EW = 1 + IDWID + PRIOR + 4;
  logic [CFWID-1:0] w_cr [13];
  logic [EW-1:0] w_in [13];
  logic [EW-1:0] r_s1 [7];
  logic [EW-1:0] r_s2 [4];
  logic [EW-1:0] r_s3 [2];
  logic [EW-1:0] w_fin;
  logic [2:0] r_v;
  assign w_cr = '{i_Confirm_Result1, i_Confirm_Result2, i_Confirm_Result3, i_Confirm_Result4,
                  i_Confirm_Result5, i_Confirm_Result6, i_Confirm_Result7, i_Confirm_Result8,
                  i_Confirm_Result9, i_Confirm_Result10, i_Confirm_Result11, i_Confirm_Result12,
                  i_Confirm_Result13};
  // Unmatched entries become all-zero so a no-match set resolves to zeros everywhere.
  for (genvar k = 0; k < 13; k++) begin : g_in
    assign w_in[k] = w_cr[k][CFWID-1] ? {1'b1, w_cr[k][IDWID+PRIOR-1:0], 4'(k + 1)} : '0;
  end
  // a is always the lower-numbered side, so >= gives ties to the lower engine.
  function automatic logic [EW-1:0] pick(input logic [EW-1:0] a, input logic [EW-1:0] b);
    return (a[EW-1] && (!b[EW-1] || a[PRIOR+3:4] >= b[PRIOR+3:4])) ? a : b;
  endfunction
  assign w_fin = pick(r_s3[0], r_s3[1]);
  always_ff @(posedge clk) begin
    for (int j = 0; j < 6; j++) r_s1[j] <= pick(w_in[2*j], w_in[2*j+1]);
    r_s1[6] <= w_in[12];
    for (int j = 0; j < 3; j++) r_s2[j] <= pick(r_s1[2*j], r_s1[2*j+1]);
    r_s2[3] <= r_s1[6];
    for (int j = 0; j < 2; j++) r_s3[j] <= pick(r_s2[2*j], r_s2[2*j+1]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      o_Valid <= 1'b0;
      {o_Match, o_Rule_ID, o_Rule_Prior, o_Engine_Idx} <= '0;
    end else begin
      r_v <= {r_v[1:0], i_Valid};
      o_Valid <= r_v[2];
      if (r_v[2]) {o_Match, o_Rule_ID, o_Rule_Prior, o_Engine_Idx} <= w_fin;
    end
  end
`ifdef PRIORITY_RESOLVER_STATS_EN
  logic [31:0] r_hit, r_miss;
  always_ff @(posedge clk) begin
    if (rst || i_Stats_Clear) begin
      r_hit <= '0;
      r_miss <= '0;
    end else if (o_Valid) begin
      r_hit <= r_hit + 32'(o_Match && r_hit != '1);
      r_miss <= r_miss + 32'(!o_Match && r_miss != '1);
    end
  end
  assign o_Hit_Count = r_hit;
  assign o_Miss_Count = r_miss;
`endif
endmodule
